// File: rtl/evm_tally_pkg.sv
// Shared types and helpers for the EVM vote tally.
package evm_tally_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } evm_state_t;

  // NOTA always occupies the slot just past the last candidate.
  function automatic int unsigned nota_idx(input int unsigned n);
    return n;
  endfunction

endpackage

// File: rtl/evm_tally_if.sv
// Ballot handshake between the ballot-unit front end and the tally.
interface evm_tally_if #(
  parameter int unsigned SEL_W = 4
);
  logic             voter_auth;
  logic             ballot_valid;
  logic [SEL_W-1:0] ballot_sel;
  logic             ballot_ready;

  modport master (output voter_auth, output ballot_valid, output ballot_sel, input ballot_ready);
  modport slave  (input voter_auth, input ballot_valid, input ballot_sel, output ballot_ready);
endinterface

// File: rtl/evm_tally_max_scan.sv
// Iterative argmax: walks one slot per cycle while en, lowest index wins ties.
module evm_max_scan #(
  parameter int unsigned N_SLOTS = 9,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SEL_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [SEL_W-1:0] idx,
  output logic             last_c,
  output logic [SEL_W-1:0] winner_idx,
  output logic             tie
);

  logic [CNT_W-1:0] max_q;

  assign last_c = en && (idx == SEL_W'(N_SLOTS - 1));

  // Running maximum; slot 0 seeds the scan so an all-zero poll ends as a tie on slot 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx        <= '0;
      max_q      <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else if (en) begin
      idx <= last_c ? '0 : idx + SEL_W'(1);
      if (idx == '0) begin
        max_q      <= cnt_in;
        winner_idx <= '0;
        tie        <= 1'b0;
      end else if (cnt_in > max_q) begin
        max_q      <= cnt_in;
        winner_idx <= idx;
        tie        <= 1'b0;
      end else if (cnt_in == max_q) begin
        tie <= 1'b1;
      end
    end else begin
      idx <= '0;
    end
  end

endmodule

// File: rtl/evm_tally.sv
// Clocked vote tally: poll FSM, armed one-shot ballots, saturating counters, winner scan.
module evm_tally
  import evm_tally_pkg::*;
#(
  parameter int unsigned N_CAND = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SEL_W  = $clog2(N_CAND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open_poll,
  input  logic              close_poll,
  evm_tally_if.slave        bal,
  input  logic [SEL_W-1:0]  read_idx,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  total_votes,
  output logic [1:0]        state_o,
  output logic              winner_valid,
  output logic [SEL_W-1:0]  winner_idx,
  output logic              tie,
  output logic              sat
);

  localparam int unsigned     N_SLOTS = N_CAND + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  evm_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt [N_SLOTS];
  logic [CNT_W-1:0] total;
  logic             armed;
  logic             sat_q;
  logic             go_open_c;
  logic             accept_c;
  logic             scan_last_c;
  logic [SEL_W-1:0] slot_c;
  logic [SEL_W-1:0] scan_idx;

  assign bal.ballot_ready = (state == OPEN) && armed;
  assign accept_c         = bal.ballot_valid && bal.ballot_ready;
  assign slot_c           = (bal.ballot_sel >= SEL_W'(N_CAND)) ? SEL_W'(nota_idx(N_CAND)) : bal.ballot_sel;

  assign state_o      = 2'(state);
  assign winner_valid = (state == DONE);
  assign total_votes  = total;
  assign sat          = sat_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; go_open_c marks entry into OPEN, which restarts the poll.
  always_comb begin
    state_nxt = state;
    go_open_c = 1'b0;
    case (state)
      IDLE: if (open_poll) begin
        state_nxt = OPEN;
        go_open_c = 1'b1;
      end
      OPEN: if (close_poll) state_nxt = SCAN;
      SCAN: if (scan_last_c) state_nxt = DONE;
      DONE: if (open_poll) begin
        state_nxt = OPEN;
        go_open_c = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter bank, total, sticky saturation and the one-ballot arming flag.
  always_ff @(posedge clk) begin
    if (rst || go_open_c) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) cnt[i] <= '0;
      total <= '0;
      sat_q <= 1'b0;
      armed <= 1'b0;
    end else if (accept_c) begin
      if (cnt[slot_c] != CNT_MAX) cnt[slot_c] <= cnt[slot_c] + CNT_W'(1);
      if (total != CNT_MAX)       total <= total + CNT_W'(1);
      if (cnt[slot_c] >= CNT_MAX - CNT_W'(1) || total >= CNT_MAX - CNT_W'(1)) sat_q <= 1'b1;
      armed <= 1'b0;
    end else if (state == OPEN && close_poll) begin
      armed <= 1'b0;
    end else if (state == OPEN && bal.voter_auth) begin
      armed <= 1'b1;
    end
  end

  // Readback of any slot; out-of-range indices read as zero.
  always_comb begin
    read_count = '0;
    if (read_idx <= SEL_W'(N_CAND)) read_count = cnt[read_idx];
  end

  evm_max_scan #(
    .N_SLOTS (N_SLOTS),
    .CNT_W   (CNT_W),
    .SEL_W   (SEL_W)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .clear      (go_open_c),
    .en         (state == SCAN),
    .cnt_in     (cnt[scan_idx]),
    .idx        (scan_idx),
    .last_c     (scan_last_c),
    .winner_idx (winner_idx),
    .tie        (tie)
  );

endmodule
